// File: rtl/bp_be_pkg.sv
// Shared types for the back-end loop-inference scheduler.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_li_idle,
    e_li_start,
    e_li_discover,
    e_li_resp
  } bp_be_li_sched_state_e;

endpackage

// File: rtl/bp_be_li_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module bp_be_li_rr_arb
  import bp_be_pkg::*;
#(
  parameter int  num_req_p   = 4,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]   req,
  input  logic [id_width_lp-1:0] ptr,
  output logic [num_req_p-1:0]   grant,
  output logic [id_width_lp-1:0] id
);

  logic [id_width_lp-1:0] idx;
  logic                   found;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    id    = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_width_lp'((int'(ptr) + i) % num_req_p);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/bp_be_loop_inference_scheduler.sv
// Time-shares one loop-inference unit among striding-load detector slots:
// round-robin grant, discovery handshake, watchdog and valid/ready response.
module bp_be_loop_inference_scheduler
  import bp_be_pkg::*;
#(
  parameter int  num_req_p        = 4,
  parameter int  vaddr_width_p    = 39,
  parameter int  iter_width_p     = 8,
  parameter int  timeout_cycles_p = 1024,
  localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
  input  logic [num_req_p-1:0]               req_confirm_i,
  output logic [num_req_p-1:0]               grant_o,
  output logic                               li_start_discovery_o,
  output logic [vaddr_width_p-1:0]           li_striding_pc_o,
  output logic                               li_confirm_discovery_o,
  input  logic [iter_width_p-1:0]            li_remaining_iterations_i,
  input  logic                               li_v_i,
  output logic                               li_yumi_o,
  output logic                               resp_v_o,
  output logic [id_width_lp-1:0]             resp_id_o,
  output logic [iter_width_p-1:0]            resp_iterations_o,
  output logic                               resp_timeout_o,
  input  logic                               resp_ready_i,
  output logic                               busy_o,
  output logic                               error_o
);

  localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_limit_lp = cnt_width_lp'(timeout_cycles_p);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp  = cnt_width_lp'(timeout_cycles_p - 1);

  bp_be_li_sched_state_e state_q, state_n;

  logic [id_width_lp-1:0]   ptr_q, ptr_n, id_q, arb_id;
  logic [num_req_p-1:0]     arb_grant, grant_q;
  logic [vaddr_width_p-1:0] req_pc_arr [num_req_p];
  logic [vaddr_width_p-1:0] pc_q;
  logic [cnt_width_lp-1:0]  cnt_q;
  logic [iter_width_p-1:0]  iter_q;
  logic confirm_sent_q, confirm_q, timeout_q, error_q;
  logic slot_req, slot_confirm, cancel, timeout_hit;

  for (genvar g = 0; g < num_req_p; g++) begin : g_pc
    assign req_pc_arr[g] = req_pc_i[g*vaddr_width_p +: vaddr_width_p];
  end

  bp_be_li_rr_arb #(.num_req_p(num_req_p)) arb (
    .req   (req_v_i),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .id    (arb_id)
  );

  assign ptr_n        = (arb_id == id_width_lp'(num_req_p - 1)) ? '0 : arb_id + 1'b1;
  assign slot_req     = req_v_i[id_q];
  assign slot_confirm = req_confirm_i[id_q];
  // A confirm in the same cycle as a withdrawal keeps the slot alive.
  assign cancel       = !slot_req && !confirm_sent_q && !slot_confirm;
  assign timeout_hit  = (cnt_q >= cnt_last_lp);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_li_idle;
    else            state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      e_li_idle:     if (|req_v_i) state_n = e_li_start;
      e_li_start:    state_n = e_li_discover;
      e_li_discover: begin
        if (li_v_i)                             state_n = e_li_resp;
        else if (cancel)                        state_n = e_li_idle;
        else if (timeout_hit && !confirm_sent_q) state_n = e_li_resp;
      end
      e_li_resp:     if (resp_ready_i) state_n = e_li_idle;
      default:       state_n = e_li_idle;
    endcase
  end

  always_comb begin
    li_start_discovery_o = 1'b0;
    li_yumi_o            = 1'b0;
    resp_v_o             = 1'b0;
    busy_o               = 1'b1;
    unique case (state_q)
      e_li_idle:     busy_o = 1'b0;
      e_li_start:    li_start_discovery_o = 1'b1;
      e_li_discover: li_yumi_o = li_v_i;
      e_li_resp:     resp_v_o = 1'b1;
      default:       busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q          <= '0;
      id_q           <= '0;
      pc_q           <= '0;
      grant_q        <= '0;
      cnt_q          <= '0;
      iter_q         <= '0;
      confirm_sent_q <= 1'b0;
      confirm_q      <= 1'b0;
      timeout_q      <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      grant_q   <= '0;
      confirm_q <= 1'b0;
      unique case (state_q)
        e_li_idle: if (|req_v_i) begin
          grant_q <= arb_grant;
          id_q    <= arb_id;
          pc_q    <= req_pc_arr[arb_id];
          ptr_q   <= ptr_n;
        end
        e_li_start: begin
          cnt_q          <= '0;
          confirm_sent_q <= 1'b0;
        end
        e_li_discover: begin
          if (cnt_q != cnt_limit_lp) cnt_q <= cnt_q + 1'b1;
          if (state_n == e_li_discover && slot_confirm && !confirm_sent_q) begin
            confirm_q      <= 1'b1;
            confirm_sent_q <= 1'b1;
          end
          if (li_v_i) begin
            iter_q    <= li_remaining_iterations_i;
            timeout_q <= 1'b0;
          end else if (!cancel && timeout_hit) begin
            // A confirmed unit cannot be restarted, so only flag it and wait.
            if (confirm_sent_q) error_q <= 1'b1;
            else begin
              iter_q    <= '0;
              timeout_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o                = grant_q;
  assign li_striding_pc_o       = pc_q;
  assign li_confirm_discovery_o = confirm_q;
  assign resp_id_o              = id_q;
  assign resp_iterations_o      = iter_q;
  assign resp_timeout_o         = timeout_q;
  assign error_o                = error_q;

endmodule

// File: tb/tb_bp_be_loop_inference_scheduler.sv
// Randomized scenario bench for the loop-inference scheduler with a
// transaction-level reference model (round-robin pick, timing expectations).
module tb_bp_be_loop_inference_scheduler;

  localparam int NR = 4;
  localparam int VA = 39;
  localparam int IW = 8;
  localparam int TO = 1024;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [NR-1:0]   req_v_i, req_confirm_i, grant_o;
  logic [VA-1:0]   pcs [NR];
  logic [NR*VA-1:0] req_pc_i;
  logic            li_start_discovery_o, li_confirm_discovery_o, li_v_i, li_yumi_o;
  logic [VA-1:0]   li_striding_pc_o;
  logic [IW-1:0]   li_remaining_iterations_i, resp_iterations_o;
  logic            resp_v_o, resp_timeout_o, resp_ready_i, busy_o, error_o;
  logic [1:0]      resp_id_o;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  bit err_m  = 1'b0;

  assign req_pc_i = {pcs[3], pcs[2], pcs[1], pcs[0]};

  always #5 clk_i = ~clk_i;

  bp_be_loop_inference_scheduler #(
    .num_req_p(NR), .vaddr_width_p(VA), .iter_width_p(IW), .timeout_cycles_p(TO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_pc_i(req_pc_i),
    .req_confirm_i(req_confirm_i), .grant_o(grant_o),
    .li_start_discovery_o(li_start_discovery_o), .li_striding_pc_o(li_striding_pc_o),
    .li_confirm_discovery_o(li_confirm_discovery_o),
    .li_remaining_iterations_i(li_remaining_iterations_i), .li_v_i(li_v_i),
    .li_yumi_o(li_yumi_o), .resp_v_o(resp_v_o), .resp_id_o(resp_id_o),
    .resp_iterations_o(resp_iterations_o), .resp_timeout_o(resp_timeout_o),
    .resp_ready_i(resp_ready_i), .busy_o(busy_o), .error_o(error_o)
  );

  function automatic int pick(input logic [NR-1:0] req, input int ptr);
    for (int i = 0; i < NR; i++) begin
      if (req[2'((ptr + i) % NR)]) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [VA-1:0] rand_pc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[VA-1:0];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_start(input int id);
    logic [NR-1:0] exp_g;
    exp_g = '0;
    exp_g[2'(id)] = 1'b1;
    #1;
    checks++;
    if (grant_o !== exp_g || li_start_discovery_o !== 1'b1 || li_striding_pc_o !== pcs[id]
        || busy_o !== 1'b1 || resp_v_o !== 1'b0) begin
      errors++;
      $display("FAIL start: grant=%b start=%b pc=%h busy=%b resp_v=%b, expected grant=%b start=1 pc=%h busy=1 resp_v=0",
               grant_o, li_start_discovery_o, li_striding_pc_o, busy_o, resp_v_o, exp_g, pcs[id]);
    end
    ptr_m = (id + 1) % NR;
  endtask

  // One full transaction from IDLE. conf_dly/liv_dly are DISCOVER cycle numbers
  // (1-based, 0 = never). drop_mode: 1 withdraws after confirm, 2 on confirm.
  task automatic serve(input int conf_dly, input int liv_dly, input logic [IW-1:0] est,
                       input int stall, input int drop_mode);
    int id, d;
    bit done, exp_to, exp_conf, exp_err;
    logic [IW-1:0] exp_iter;
    id = pick(req_v_i, ptr_m);
    tick();
    check_start(id);
    tick();
    d = 1; done = 1'b0; exp_to = 1'b0; exp_iter = '0;
    while (!done && d <= 1100) begin
      req_confirm_i = '0;
      if (conf_dly > 0 && (d == conf_dly || d == conf_dly + 2)) req_confirm_i[2'(id)] = 1'b1;
      if ((drop_mode == 1 && conf_dly > 0 && d > conf_dly) ||
          (drop_mode == 2 && conf_dly > 0 && d >= conf_dly)) req_v_i[2'(id)] = 1'b0;
      li_v_i = (d == liv_dly);
      li_remaining_iterations_i = (d == liv_dly) ? est : IW'($urandom());
      #1;
      exp_conf = (conf_dly > 0) && (d == conf_dly + 1);
      if (conf_dly > 0 && conf_dly < TO && d > TO) err_m = 1'b1;
      exp_err = err_m;
      checks++;
      if (li_confirm_discovery_o !== exp_conf || li_yumi_o !== (d == liv_dly) ||
          resp_v_o !== 1'b0 || busy_o !== 1'b1 || error_o !== exp_err ||
          grant_o !== '0 || li_start_discovery_o !== 1'b0) begin
        errors++;
        $display("FAIL discover d=%0d: confirm=%b yumi=%b resp_v=%b busy=%b error=%b grant=%b start=%b, expected confirm=%b yumi=%b resp_v=0 busy=1 error=%b grant=0 start=0",
                 d, li_confirm_discovery_o, li_yumi_o, resp_v_o, busy_o, error_o, grant_o,
                 li_start_discovery_o, exp_conf, (d == liv_dly), exp_err);
      end
      if (d == liv_dly) begin
        done = 1'b1; exp_iter = est; exp_to = 1'b0;
      end else if (conf_dly == 0 && d == TO) begin
        done = 1'b1; exp_iter = '0; exp_to = 1'b1;
      end
      tick();
      d++;
    end
    req_confirm_i = '0;
    li_v_i = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL discover_bound: no exit after %0d cycles, expected exit by liv=%0d or watchdog", d, liv_dly);
      return;
    end
    for (int s = 0; s <= stall; s++) begin
      resp_ready_i = (s == stall);
      li_v_i = 1'b1;
      #1;
      checks++;
      if (resp_v_o !== 1'b1 || resp_id_o !== 2'(id) || resp_iterations_o !== exp_iter ||
          resp_timeout_o !== exp_to || li_yumi_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL resp s=%0d: v=%b id=%0d iter=%0d to=%b yumi=%b busy=%b, expected v=1 id=%0d iter=%0d to=%b yumi=0 busy=1",
                 s, resp_v_o, resp_id_o, resp_iterations_o, resp_timeout_o, li_yumi_o, busy_o,
                 id, exp_iter, exp_to);
      end
      tick();
    end
    resp_ready_i = 1'b0;
    li_v_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || resp_v_o !== 1'b0 || grant_o !== '0 || error_o !== err_m) begin
      errors++;
      $display("FAIL idle_after_resp: busy=%b resp_v=%b grant=%b error=%b, expected busy=0 resp_v=0 grant=0 error=%b",
               busy_o, resp_v_o, grant_o, error_o, err_m);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (grant_o !== '0 || li_start_discovery_o !== 1'b0 || li_striding_pc_o !== '0 ||
        li_confirm_discovery_o !== 1'b0 || li_yumi_o !== 1'b0 || resp_v_o !== 1'b0 ||
        resp_id_o !== '0 || resp_iterations_o !== '0 || resp_timeout_o !== 1'b0 ||
        busy_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: grant=%b start=%b pc=%h conf=%b yumi=%b rv=%b id=%0d it=%0d to=%b busy=%b err=%b, expected all 0",
               name, grant_o, li_start_discovery_o, li_striding_pc_o, li_confirm_discovery_o,
               li_yumi_o, resp_v_o, resp_id_o, resp_iterations_o, resp_timeout_o, busy_o, error_o);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    req_v_i = '0; req_confirm_i = '0; li_v_i = 1'b0; resp_ready_i = 1'b0;
    li_remaining_iterations_i = '0;
    for (int i = 0; i < NR; i++) pcs[i] = rand_pc();
    #12;
    check_all_zero("reset_held");
    tick();
    reset_n_i = 1'b1;
    tick();
    #1;
    check_all_zero("reset_released");
    ptr_m = 0; err_m = 1'b0;
  endtask

  task automatic test_round_robin_held();
    req_v_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int c;
      c = $urandom_range(1, 5);
      serve(c, c + $urandom_range(1, 8), IW'($urandom()), $urandom_range(0, 3), 0);
    end
    req_v_i = '0;
  endtask

  task automatic test_basic();
    req_v_i = 4'b0001;
    pcs[0] = 39'h0_8000_1000;
    serve(5, 20, 8'd37, 10, 1);
    req_v_i = '0;
  endtask

  task automatic test_timeout();
    req_v_i = 4'b0100;
    serve(0, 0, '0, 2, 0);
    req_v_i = '0;
  endtask

  task automatic test_cancel();
    req_v_i = 4'b0010;
    tick();
    check_start(1);
    tick();
    tick();
    req_v_i = 4'b1000;
    pcs[3] = rand_pc();
    #1;
    checks++;
    if (busy_o !== 1'b1 || resp_v_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_pre: busy=%b resp_v=%b, expected busy=1 resp_v=0", busy_o, resp_v_o);
    end
    tick();
    #1;
    checks++;
    if (busy_o !== 1'b0 || resp_v_o !== 1'b0 || grant_o !== '0) begin
      errors++;
      $display("FAIL cancel_idle: busy=%b resp_v=%b grant=%b, expected busy=0 resp_v=0 grant=0",
               busy_o, resp_v_o, grant_o);
    end
    serve(2, 9, IW'($urandom()), 1, 1);
    req_v_i = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int c, dm;
      req_v_i = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) pcs[i] = rand_pc();
      c  = $urandom_range(0, 8);
      dm = (c == 0) ? 0 : $urandom_range(0, 2);
      serve(c, c + $urandom_range(1, 15), IW'($urandom()), $urandom_range(0, 4), dm);
    end
    req_v_i = '0;
  endtask

  task automatic test_error();
    req_v_i = 4'b0001;
    serve(3, TO + 6, 8'd99, 1, 1);
    req_v_i = '0;
  endtask

  task automatic test_reset_mid_discover();
    req_v_i = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    li_v_i = 1'b1; req_confirm_i = 4'b1111; resp_ready_i = 1'b1;
    reset_n_i = 1'b0;
    #1;
    check_all_zero("reset_mid_discover");
    li_v_i = 1'b0; req_confirm_i = '0; resp_ready_i = 1'b0; req_v_i = '0;
    tick();
    reset_n_i = 1'b1;
    ptr_m = 0; err_m = 1'b0;
    req_v_i = 4'b1000;
    serve(1, 4, 8'd200, 0, 1);
    req_v_i = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin_held();
    test_basic();
    test_timeout();
    test_cancel();
    test_random();
    test_error();
    test_reset_mid_discover();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
